// File: rtl/router_pkg.sv
// router_pkg: shared FSM encoding and header field layout
// for the 1x3 router egress path.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;
  localparam int ADDR_MSB  = 1;
  localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;
  localparam int CNT_W     = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    DRAIN
  } sched_state_e;

  function automatic logic [LEN_W-1:0] hdr_len(
    input logic [7:0] h
  );
    return h[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [ADDR_MSB:0] hdr_addr(
    input logic [7:0] h
  );
    return h[ADDR_MSB:0];
  endfunction

  function automatic logic [1:0] rr_next(
    input logic [1:0] p
  );
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_egress_sched_if.sv
// router_egress_sched_if: 8-bit ready/valid egress stream
// with packet framing and parity-error sideband.
interface router_egress_sched_if #(
  parameter int DW = 8
);

  logic [DW-1:0] egress_data;
  logic          egress_valid;
  logic          egress_ready;
  logic          egress_sop;
  logic          egress_eop;
  logic [1:0]    egress_port;
  logic          egress_err;

  modport master (
    output egress_data,
    output egress_valid,
    output egress_sop,
    output egress_eop,
    output egress_port,
    output egress_err,
    input  egress_ready
  );

  modport slave (
    input  egress_data,
    input  egress_valid,
    input  egress_sop,
    input  egress_eop,
    input  egress_port,
    input  egress_err,
    output egress_ready
  );

endinterface

// File: rtl/router_rr_arb3.sv
// router_rr_arb3: combinational 3-way round-robin grant,
// searching upward from the pointer with wrap.
module router_rr_arb3
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [1:0]           gnt_idx,
  output logic                 gnt_vld
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  always_comb begin
    c0      = (ptr > 2'd2) ? 2'd0 : ptr;
    c1      = rr_next(c0);
    c2      = rr_next(c1);
    gnt     = '0;
    gnt_idx = 2'd0;
    gnt_vld = 1'b0;
    if (req[c0]) begin
      gnt_idx = c0;
      gnt_vld = 1'b1;
    end else if (req[c1]) begin
      gnt_idx = c1;
      gnt_vld = 1'b1;
    end else if (req[c2]) begin
      gnt_idx = c2;
      gnt_vld = 1'b1;
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/router_egress_sched.sv
// router_egress_sched: drains whole packets from the three
// output FIFOs onto one egress stream, checking parity.
module router_egress_sched
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RR_INIT    = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  vldout_0,
  input  logic                  vldout_1,
  input  logic                  vldout_2,
  input  logic [DATA_WIDTH-1:0] data_out_0,
  input  logic [DATA_WIDTH-1:0] data_out_1,
  input  logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  read_enb_0,
  output logic                  read_enb_1,
  output logic                  read_enb_2,
  output logic                  sched_busy,
  router_egress_sched_if.master eg
);

  sched_state_e state_q, state_d;

  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  goh_q, goh_d;
  logic                  hdr_rd_q, hdr_rd_d;
  logic [CNT_W-1:0]      left_q, left_d;
  logic [7:0]            acc_q, acc_d;
  logic                  vld_q, vld_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [1:0]            port_q, port_d;

  logic [NUM_PORTS-1:0]  vld_vec;
  logic [NUM_PORTS-1:0]  arb_gnt;
  logic [1:0]            arb_idx;
  logic                  arb_vld;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_vld;
  logic                  accept;
  logic                  can_adv;
  logic [LEN_W-1:0]      len;
  logic                  more;
  logic                  last;
  logic                  is_hdr;
  logic                  rd_go;

  assign vld_vec = {vldout_2, vldout_1, vldout_0};

  router_rr_arb3 u_arb (
    .req     (vld_vec),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    unique case (1'b1)
      goh_q[1]: cur_data = data_out_1;
      goh_q[2]: cur_data = data_out_2;
      default:  cur_data = data_out_0;
    endcase
  end

  assign cur_vld = |(vld_vec & goh_q);
  assign accept  = vld_q && eg.egress_ready;
  assign can_adv = !vld_q || eg.egress_ready;
  assign len     = hdr_len(cur_data);

  // What the next read would be: header, last byte, or none.
  always_comb begin
    more   = 1'b0;
    last   = 1'b0;
    is_hdr = 1'b0;
    unique case (state_q)
      HDR: begin
        more   = 1'b1;
        is_hdr = !hdr_rd_q;
        last   = hdr_rd_q && (len == '0);
      end
      BODY: begin
        more = (left_q != '0);
        last = (left_q == CNT_W'(1));
      end
      default: ;
    endcase
    rd_go = more && cur_vld && can_adv;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    goh_d    = goh_q;
    hdr_rd_d = hdr_rd_q;
    left_d   = left_q;
    unique case (state_q)
      IDLE: begin
        hdr_rd_d = 1'b0;
        if (arb_vld) begin
          gnt_d   = arb_idx;
          goh_d   = arb_gnt;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!hdr_rd_q) begin
          hdr_rd_d = rd_go;
        end else begin
          // header is on data_out: L payload bytes + parity
          left_d = {1'b0, len} + CNT_W'(1)
                 - CNT_W'(rd_go);
          state_d = (last && rd_go) ? DRAIN : BODY;
        end
      end
      BODY: begin
        if (rd_go) begin
          left_d = left_q - CNT_W'(1);
          if (last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && eop_q) begin
          ptr_d   = rr_next(gnt_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    port_d = port_q;
    acc_d  = acc_q;
    if (rd_go) begin
      vld_d  = 1'b1;
      sop_d  = is_hdr;
      eop_d  = last;
      port_d = gnt_q;
    end else if (accept) begin
      vld_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
    if (state_q == IDLE) begin
      acc_d = '0;
    end else if (accept && !eop_q) begin
      acc_d = acc_q ^ cur_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= 2'(RR_INIT);
      gnt_q    <= 2'd0;
      goh_q    <= '0;
      hdr_rd_q <= 1'b0;
      left_q   <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      port_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      goh_q    <= goh_d;
      hdr_rd_q <= hdr_rd_d;
      left_q   <= left_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      port_q   <= port_d;
    end
  end

  assign read_enb_0 = rd_go && goh_q[0];
  assign read_enb_1 = rd_go && goh_q[1];
  assign read_enb_2 = rd_go && goh_q[2];
  assign sched_busy = (state_q != IDLE);

  assign eg.egress_data  = cur_data;
  assign eg.egress_valid = vld_q;
  assign eg.egress_sop   = sop_q;
  assign eg.egress_eop   = eop_q;
  assign eg.egress_port  = port_q;
  assign eg.egress_err   = vld_q && eop_q
                        && (acc_q != cur_data[7:0]);

  a_rd_onehot: assert property (
    @(posedge clk) disable iff (!resetn)
    $onehot0({read_enb_2, read_enb_1, read_enb_0})
  );

endmodule
